// File: rtl/riscv_core_dcache_wbuf_drain.sv
// D-cache write-through buffer drain: holds stores pushed by the D-cache controller
// and retires them in order, one at a time, as single-beat AXI4 writes.
// An entry is removed only when its B response arrives, including error responses.
//
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_fifo_push, i_fifo_entry         store push, entry = {addr[127:64], data[63:0]}
//   o_fifo_full, o_wbuf_empty         buffer full / fully drained and idle
//   i_check_addr, o_addr_match        block-address probe (optional feature)
//   o_aw*, i_awready                  AXI write address channel
//   o_w*,  i_wready                   AXI write data channel
//   i_bvalid, i_bresp, o_bready       AXI write response channel
//   o_wr_err                          one-cycle pulse on a non-OKAY response
//
// Optional feature macro: DCACHE_WBUF_ADDR_MATCH_EN
//   defined   -> o_addr_match compares i_check_addr[63:5] against every buffered entry
//   undefined -> o_addr_match tied low, no comparators
module riscv_core_dcache_wbuf_drain #(
   parameter int DEPTH            = 8,
   parameter int ADDR_WIDTH       = 64,
   parameter int CORE_DATA_WIDTH  = 64,
   parameter int AXI_DATA_WIDTH   = 256,
   parameter int FIFO_ENTRY_WIDTH = 128
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_fifo_push,
   input  logic [FIFO_ENTRY_WIDTH-1:0]   i_fifo_entry,
   output logic                          o_fifo_full,
   output logic                          o_wbuf_empty,
   input  logic [ADDR_WIDTH-1:0]         i_check_addr,
   output logic                          o_addr_match,
   output logic                          o_awvalid,
   input  logic                          i_awready,
   output logic [ADDR_WIDTH-1:0]         o_awaddr,
   output logic [7:0]                    o_awlen,
   output logic [2:0]                    o_awsize,
   output logic [1:0]                    o_awburst,
   output logic                          o_wvalid,
   input  logic                          i_wready,
   output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
   output logic                          o_wlast,
   input  logic                          i_bvalid,
   output logic                          o_bready,
   input  logic [1:0]                    i_bresp,
   output logic                          o_wr_err
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int LANES  = AXI_DATA_WIDTH / CORE_DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                      state, state_nxt;
   logic [FIFO_ENTRY_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]            wr_ptr, rd_ptr;
   logic [CNT_W-1:0]            count;
   logic                        push_ok, pop;
   logic                        aw_done, w_done, aw_done_nxt, w_done_nxt;
   logic                        awvalid_nxt, wvalid_nxt, bready_nxt, wr_err_nxt;
   logic [ADDR_WIDTH-1:0]       head_addr;
   logic [CORE_DATA_WIDTH-1:0]  head_data;
   logic                        unused_bits;

   // ---------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------
   assign o_fifo_full  = (count == CNT_W'(DEPTH));
   // A push in the same cycle as a pop from a full buffer still sees full.
   assign push_ok      = i_fifo_push && !o_fifo_full;
   assign pop          = (state == RESP) && i_bvalid;
   assign o_wbuf_empty = (count == '0) && (state == IDLE);

   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= i_fifo_entry;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Head entry drives the AXI payload; rd_ptr only moves on the B
   // handshake, so the payload is stable for the whole transaction.
   // ---------------------------------------------------------------
   assign {head_addr, head_data} = mem[rd_ptr];

   assign o_awaddr  = {head_addr[ADDR_WIDTH-1:3], 3'b000};
   assign o_awlen   = 8'd0;
   assign o_awsize  = 3'b011;
   assign o_awburst = 2'b01;
   assign o_wdata   = {LANES{head_data}};
   assign o_wstrb   = STRB_W'(8'hFF) << {head_addr[4:3], 3'b000};
   assign o_wlast   = o_wvalid;

   // ---------------------------------------------------------------
   // Drain FSM
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         o_awvalid <= 1'b0;
         o_wvalid  <= 1'b0;
         o_bready  <= 1'b0;
         o_wr_err  <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         state     <= state_nxt;
         o_awvalid <= awvalid_nxt;
         o_wvalid  <= wvalid_nxt;
         o_bready  <= bready_nxt;
         o_wr_err  <= wr_err_nxt;
         aw_done   <= aw_done_nxt;
         w_done    <= w_done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      awvalid_nxt = o_awvalid;
      wvalid_nxt  = o_wvalid;
      bready_nxt  = o_bready;
      wr_err_nxt  = 1'b0;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      unique case (state)
         IDLE: begin
            // Looking at push_ok as well lets a push into an empty
            // buffer raise the valids on the very next cycle.
            if ((count != '0) || push_ok) begin
               state_nxt   = ISSUE;
               awvalid_nxt = 1'b1;
               wvalid_nxt  = 1'b1;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end
         end
         ISSUE: begin
            // AW and W complete independently, in either order.
            if (o_awvalid && i_awready) begin
               awvalid_nxt = 1'b0;
               aw_done_nxt = 1'b1;
            end
            if (o_wvalid && i_wready) begin
               wvalid_nxt = 1'b0;
               w_done_nxt = 1'b1;
            end
            if (aw_done_nxt && w_done_nxt) begin
               state_nxt  = RESP;
               bready_nxt = 1'b1;
            end
         end
         RESP: begin
            if (i_bvalid) begin
               state_nxt  = IDLE;
               bready_nxt = 1'b0;
               wr_err_nxt = (i_bresp != 2'b00);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Block-address probe
   // ---------------------------------------------------------------
`ifdef DCACHE_WBUF_ADDR_MATCH_EN
   logic [PTR_W-1:0] slot_off;

   always_comb begin
      o_addr_match = 1'b0;
      slot_off     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         // A slot is live when its distance from the head is below count;
         // the in-flight head is still live until its B response.
         slot_off = PTR_W'(i) - rd_ptr;
         if (({1'b0, slot_off} < count) &&
             (mem[i][CORE_DATA_WIDTH+5 +: ADDR_WIDTH-5] == i_check_addr[ADDR_WIDTH-1:5])) begin
            o_addr_match = 1'b1;
         end
      end
   end

   assign unused_bits = ^{head_addr[2:0], i_check_addr[4:0]};
`else
   assign o_addr_match = 1'b0;
   assign unused_bits  = ^{head_addr[2:0], i_check_addr};
`endif

endmodule

// File: tb/tb_riscv_core_dcache_wbuf_drain.sv
`timescale 1ns/1ps
module tb_riscv_core_dcache_wbuf_drain;

   localparam int DEPTH = 8;
`ifdef DCACHE_WBUF_ADDR_MATCH_EN
   localparam bit MATCH_EN = 1'b1;
`else
   localparam bit MATCH_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
   } ent_t;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_fifo_push;
   logic [127:0] i_fifo_entry;
   logic         o_fifo_full, o_wbuf_empty;
   logic [63:0]  i_check_addr;
   logic         o_addr_match;
   logic         o_awvalid, i_awready;
   logic [63:0]  o_awaddr;
   logic [7:0]   o_awlen;
   logic [2:0]   o_awsize;
   logic [1:0]   o_awburst;
   logic         o_wvalid, i_wready;
   logic [255:0] o_wdata;
   logic [31:0]  o_wstrb;
   logic         o_wlast;
   logic         i_bvalid, o_bready;
   logic [1:0]   i_bresp;
   logic         o_wr_err;

   always #5 i_clk = ~i_clk;

   riscv_core_dcache_wbuf_drain dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_fifo_push(i_fifo_push), .i_fifo_entry(i_fifo_entry),
      .o_fifo_full(o_fifo_full), .o_wbuf_empty(o_wbuf_empty),
      .i_check_addr(i_check_addr), .o_addr_match(o_addr_match),
      .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
      .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
      .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
      .o_wstrb(o_wstrb), .o_wlast(o_wlast),
      .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
      .o_wr_err(o_wr_err)
   );

   int   total = 0;
   int   bad   = 0;
   ent_t q[$];   // reference model: entries the buffer should hold, head first

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_match(input logic [63:0] a);
      logic m;
      m = 1'b0;
      foreach (q[i]) if (q[i].addr[63:5] == a[63:5]) m = 1'b1;
      return m;
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.addr = 64'h3000 + 64'($urandom_range(0, 255));
      e.data = {$urandom, $urandom};
      return e;
   endfunction

   task automatic probe(input logic [63:0] a);
      i_check_addr = a;
      #1;
      chk("addr_match", o_addr_match, MATCH_EN ? model_match(a) : 1'b0);
   endtask

   task automatic push(input ent_t e);
      chk("full_before_push", o_fifo_full, q.size() == DEPTH);
      i_fifo_push  = 1'b1;
      i_fifo_entry = e;
      if (q.size() < DEPTH) q.push_back(e);
      tick();
      i_fifo_push = 1'b0;
   endtask

   task automatic chk_payload(input string tag, input ent_t e);
      logic [31:0]  strb;
      logic [255:0] wd;
      for (int b = 0; b < 32; b++) strb[b] = ((b / 8) == int'(e.addr[4:3]));
      for (int l = 0; l < 4; l++) wd[l*64 +: 64] = e.data;
      chk({tag, ":awaddr"},  o_awaddr, e.addr & ~64'h7);
      chk({tag, ":wstrb"},   o_wstrb, strb);
      chk({tag, ":wdata"},   o_wdata, wd);
      chk({tag, ":awlen"},   o_awlen, 8'd0);
      chk({tag, ":awsize"},  o_awsize, 3'd3);
      chk({tag, ":awburst"}, o_awburst, 2'd1);
   endtask

   // Acts as the AXI slave for one transaction and retires the model head.
   task automatic drain(input int awdly, input int wdly, input int bdly,
                        input logic [1:0] resp, input bit push_en, input ent_t pe);
      int   n, k;
      bit   aw_d, w_d, aw_hit, w_hit;
      ent_t h;
      n = 0;
      while (!o_awvalid && n < 50) begin
         tick();
         n++;
      end
      chk("aw_start", o_awvalid, 1'b1);
      if (q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL model_empty observed=transaction expected=none");
         return;
      end
      h = q[0];
      chk_payload("issue_start", h);
      aw_d = 1'b0;
      w_d  = 1'b0;
      k    = 0;
      while (!(aw_d && w_d) && k < 60) begin
         i_awready = (k >= awdly);
         i_wready  = (k >= wdly);
         chk("awvalid", o_awvalid, !aw_d);
         chk("wvalid", o_wvalid, !w_d);
         if (!w_d) chk("wlast", o_wlast, 1'b1);
         chk("bready_in_issue", o_bready, 1'b0);
         aw_hit = o_awvalid && i_awready;
         w_hit  = o_wvalid && i_wready;
         tick();
         k++;
         aw_d |= aw_hit;
         w_d  |= w_hit;
      end
      i_awready = 1'b0;
      i_wready  = 1'b0;
      chk("issue_done", aw_d && w_d, 1'b1);
      chk_payload("issue_end", h);
      for (int j = 0; j <= bdly; j++) begin
         chk("bready", o_bready, 1'b1);
         chk("no_dup_aw", o_awvalid, 1'b0);
         chk("no_dup_w", o_wvalid, 1'b0);
         i_bvalid = (j == bdly);
         i_bresp  = resp;
         if (j == bdly && push_en) begin
            chk("full_at_b_push", o_fifo_full, q.size() == DEPTH);
            i_fifo_push  = 1'b1;
            i_fifo_entry = pe;
            if (q.size() < DEPTH) q.push_back(pe);
         end
         tick();
      end
      i_bvalid    = 1'b0;
      i_fifo_push = 1'b0;
      void'(q.pop_front());
      chk("wr_err", o_wr_err, resp != 2'b00);
      chk("bready_drop", o_bready, 1'b0);
      chk("full_after_pop", o_fifo_full, q.size() == DEPTH);
      chk("empty_after_pop", o_wbuf_empty, q.size() == 0);
      tick();
      chk("wr_err_pulse", o_wr_err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ent_t       e;
      int         cnt, guard;
      logic [1:0] rsp;

      i_rst_n = 1'b0; i_fifo_push = 1'b0; i_fifo_entry = '0; i_check_addr = '0;
      i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;

      // Reset state
      #12;
      chk("rst_full", o_fifo_full, 1'b0);
      chk("rst_empty", o_wbuf_empty, 1'b1);
      chk("rst_awvalid", o_awvalid, 1'b0);
      chk("rst_wvalid", o_wvalid, 1'b0);
      chk("rst_bready", o_bready, 1'b0);
      chk("rst_wr_err", o_wr_err, 1'b0);
      chk("rst_match", o_addr_match, 1'b0);
      tick();
      i_rst_n = 1'b1;
      tick();

      // Single store into an empty buffer: valids one cycle after the push
      e.addr = 64'h1008;
      e.data = 64'hA5;
      push(e);
      chk("first_awvalid_n1", o_awvalid, 1'b1);
      chk("first_wvalid_n1", o_wvalid, 1'b1);
      chk("first_awaddr", o_awaddr, 64'h1008);
      chk("first_wstrb", o_wstrb, 32'h0000FF00);
      drain(0, 0, 0, 2'b00, 1'b0, e);
      chk("first_empty", o_wbuf_empty, 1'b1);

      // Address probe around a buffered block
      e.addr = 64'h2010;
      e.data = 64'h1234;
      push(e);
      probe(64'h2018);
      chk("match_same_block", o_addr_match, MATCH_EN);
      probe(64'h2020);
      chk("match_next_block", o_addr_match, 1'b0);
      drain(1, 0, 0, 2'b00, 1'b0, e);
      probe(64'h2018);
      chk("match_after_pop", o_addr_match, 1'b0);

      // Fill while AW is stalled, overflow push dropped, drain in order
      for (int i = 0; i < DEPTH; i++) push(rand_ent());
      chk("fill_full", o_fifo_full, 1'b1);
      chk("fill_not_empty", o_wbuf_empty, 1'b0);
      probe(q[3].addr);
      push(rand_ent());
      chk("overflow_still_full", o_fifo_full, 1'b1);
      drain(3, 0, 0, 2'b00, 1'b0, e);   // W completes 3 cycles before AW
      drain(0, 2, 1, 2'b00, 1'b0, e);   // AW first
      drain(1, 1, 2, 2'b00, 1'b0, e);   // same-cycle completion
      while (q.size() > 0)
         drain($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 2'b00, 1'b0, e);
      chk("fill_drained_empty", o_wbuf_empty, 1'b1);

      // Error response: entry still retired, next entry issued
      push(rand_ent());
      push(rand_ent());
      drain(0, 0, 1, 2'b10, 1'b0, e);
      drain(0, 0, 0, 2'b00, 1'b0, e);
      chk("err_drained_empty", o_wbuf_empty, 1'b1);

      // Full + B handshake + push in the same cycle: push dropped
      for (int i = 0; i < DEPTH; i++) push(rand_ent());
      chk("full_again", o_fifo_full, 1'b1);
      drain(0, 0, 0, 2'b00, 1'b1, rand_ent());
      chk("count_depth_minus_1", o_fifo_full, 1'b0);
      while (q.size() > 0) drain(0, 0, 0, 2'b00, 1'b0, e);
      chk("drop_drained_empty", o_wbuf_empty, 1'b1);

      // Randomized rounds against the model
      for (int r = 0; r < 6; r++) begin
         cnt = $urandom_range(1, DEPTH + 1);
         for (int i = 0; i < cnt; i++) push(rand_ent());
         for (int i = 0; i < 3; i++) probe(64'h3000 + 64'($urandom_range(0, 255)));
         guard = 0;
         while (q.size() > 0 && guard < 40) begin
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drain($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  rsp, $urandom_range(0, 1) == 1, rand_ent());
            probe(64'h3000 + 64'($urandom_range(0, 255)));
            guard++;
         end
         chk("round_empty", o_wbuf_empty, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
